// File: rtl/uart_frame_pkg.sv
// Shared definitions for the UART frame drain: state encoding,
// default header bytes and the 12-bit sample byte split.
package uart_frame_pkg;

    localparam int         SAMPLE_W = 12;
    localparam logic [7:0] HDR0_DEF = 8'hA5;
    localparam logic [7:0] HDR1_DEF = 8'h5A;

    // Nine states do not fit in three bits, so the encoding is four bits wide.
    typedef enum logic [3:0] {
        ST_IDLE,
        ST_HDR0,
        ST_HDR1,
        ST_FETCH,
        ST_WAIT,
        ST_SEND_HI,
        ST_SEND_LO,
        ST_CSUM,
        ST_DONE
    } state_t;

    function automatic logic [7:0] sample_byte(
        input logic [SAMPLE_W-1:0] d,
        input logic                hi
    );
        return hi ? {4'h0, d[11:8]} : d[7:0];
    endfunction

endpackage

// File: rtl/uart_fifo_frame_drain_if.sv
// Byte stream handshake towards the UART transmitter.
interface uart_fifo_frame_drain_if;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );

endinterface

// File: rtl/uart_byte_skid.sv
// One-entry output register; holds the byte stable while the
// transmitter applies backpressure.
module uart_byte_skid (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    input  logic       load_valid,
    input  logic [7:0] load_data,
    uart_fifo_frame_drain_if.master tx
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx.tx_valid <= 1'b0;
            tx.tx_data  <= 8'h00;
        end else if (flush) begin
            tx.tx_valid <= 1'b0;
            tx.tx_data  <= 8'h00;
        end else if (!tx.tx_valid || tx.tx_ready) begin
            tx.tx_valid <= load_valid;
            tx.tx_data  <= load_data;
        end
    end

endmodule

// File: rtl/uart_fifo_frame_drain.sv
// Read-side FIFO drain: frames FRAME_LEN samples as a header,
// hi/lo sample bytes and an XOR checksum for the UART.
module uart_fifo_frame_drain
    import uart_frame_pkg::*;
#(
    parameter int         DATA_WIDTH = SAMPLE_W,
    parameter int         LVL_WIDTH  = 11,
    parameter int         FRAME_LEN  = 256,
    parameter logic [7:0] HDR0       = HDR0_DEF,
    parameter logic [7:0] HDR1       = HDR1_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_rd_empty,
    input  logic [LVL_WIDTH-1:0]  fifo_rd_water_level,
    uart_fifo_frame_drain_if.master tx,
    output logic                  busy,
    output logic                  frame_done,
    output logic [LVL_WIDTH-1:0]  sample_cnt
);

    localparam logic [LVL_WIDTH-1:0] FRAME_LVL = LVL_WIDTH'(FRAME_LEN);

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic [7:0]            csum_q, csum_d;
    logic [LVL_WIDTH-1:0]  cnt_d;
    logic                  xfer;
    logic                  start_ok;
    logic                  load_valid;
    logic [7:0]            load_data;

    assign xfer       = tx.tx_valid && tx.tx_ready;
    assign busy       = (state_q != ST_IDLE);
    assign frame_done = (state_q == ST_DONE);
    assign start_ok   = (state_q == ST_IDLE) && (state_d == ST_HDR0);

    always_comb begin
        state_d    = state_q;
        fifo_rd_en = 1'b0;
        unique case (state_q)
            ST_IDLE:
                if (start && fifo_rd_water_level >= FRAME_LVL)
                    state_d = ST_HDR0;
            ST_HDR0:    if (xfer) state_d = ST_HDR1;
            ST_HDR1:    if (xfer) state_d = ST_FETCH;
            ST_FETCH:
                if (!fifo_rd_empty) begin
                    fifo_rd_en = 1'b1;
                    state_d    = ST_WAIT;
                end
            ST_WAIT:    state_d = ST_SEND_HI;
            ST_SEND_HI: if (xfer) state_d = ST_SEND_LO;
            ST_SEND_LO:
                if (xfer)
                    state_d = (sample_cnt < FRAME_LVL) ? ST_FETCH : ST_CSUM;
            ST_CSUM:    if (xfer) state_d = ST_DONE;
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
        if (abort) begin
            state_d    = ST_IDLE;
            fifo_rd_en = 1'b0;
        end
    end

    always_comb begin
        hold_d = hold_q;
        csum_d = csum_q;
        cnt_d  = sample_cnt;
        if (state_q == ST_WAIT && !abort)
            hold_d = fifo_rd_data;
        if (start_ok) begin
            csum_d = 8'h00;
            cnt_d  = '0;
        end else begin
            if (xfer && (state_q == ST_SEND_HI || state_q == ST_SEND_LO))
                csum_d = csum_q ^ tx.tx_data;
            if (fifo_rd_en && sample_cnt != FRAME_LVL)
                cnt_d = sample_cnt + 1'b1;
        end
    end

    // The output register is loaded from the next state, so the byte on
    // the wire always matches the state that owns it.
    always_comb begin
        load_valid = 1'b1;
        load_data  = 8'h00;
        unique case (state_d)
            ST_HDR0:    load_data = HDR0;
            ST_HDR1:    load_data = HDR1;
            ST_SEND_HI: load_data = sample_byte(hold_d, 1'b1);
            ST_SEND_LO: load_data = sample_byte(hold_d, 1'b0);
            ST_CSUM:    load_data = csum_d;
            default:    load_valid = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            hold_q     <= '0;
            csum_q     <= 8'h00;
            sample_cnt <= '0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            csum_q     <= csum_d;
            sample_cnt <= cnt_d;
        end
    end

    uart_byte_skid u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (abort),
        .load_valid (load_valid),
        .load_data  (load_data),
        .tx         (tx)
    );

endmodule

// File: tb/tb_uart_fifo_frame_drain.sv
// Directed bench for uart_fifo_frame_drain with a FIFO model
// and a byte scoreboard.
module tb_uart_fifo_frame_drain;

    localparam int FL = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic        fifo_rd_en;
    logic [11:0] fifo_rd_data = 12'h000;
    logic        fifo_rd_empty;
    logic [10:0] fifo_rd_water_level;
    logic        busy;
    logic        frame_done;
    logic [10:0] sample_cnt;

    uart_fifo_frame_drain_if tx_if();

    logic [11:0] mem [64];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    logic        force_empty;
    logic        lvl_force;
    logic [10:0] lvl_val;

    int chk_cnt  = 0;
    int err_cnt  = 0;
    int xfer_cnt = 0;
    int rd_cnt   = 0;
    int done_cnt = 0;

    logic [7:0] exp_q[$];
    logic [7:0] exp_b;
    logic       prev_stall = 1'b0;
    logic       prev_abort = 1'b0;
    logic [7:0] prev_data  = 8'h00;

    assign fifo_rd_empty = force_empty || (wr_ptr == rd_ptr);
    assign fifo_rd_water_level = lvl_force ? lvl_val : 11'(wr_ptr - rd_ptr);

    always #5 clk = ~clk;

    uart_fifo_frame_drain #(
        .FRAME_LEN (FL)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .start               (start),
        .abort               (abort),
        .fifo_rd_en          (fifo_rd_en),
        .fifo_rd_data        (fifo_rd_data),
        .fifo_rd_empty       (fifo_rd_empty),
        .fifo_rd_water_level (fifo_rd_water_level),
        .tx                  (tx_if),
        .busy                (busy),
        .frame_done          (frame_done),
        .sample_cnt          (sample_cnt)
    );

    // FIFO read port without output register: data follows rd_en by one cycle.
    always @(posedge clk) begin
        if (fifo_rd_en) begin
            fifo_rd_data <= mem[rd_ptr % 64];
            rd_ptr       <= rd_ptr + 1;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (tx_if.tx_valid && tx_if.tx_ready) begin
                xfer_cnt++;
                chk_cnt++;
                assert (exp_q.size() > 0) else begin
                    err_cnt++;
                    $error("FAIL tx_unexpected: observed %h, expected no byte", tx_if.tx_data);
                end
                if (exp_q.size() > 0) begin
                    exp_b = exp_q.pop_front();
                    chk_cnt++;
                    assert (tx_if.tx_data === exp_b) else begin
                        err_cnt++;
                        $error("FAIL tx_byte: observed %h, expected %h", tx_if.tx_data, exp_b);
                    end
                end
            end
            if (prev_stall && !prev_abort) begin
                chk_cnt++;
                assert (tx_if.tx_valid === 1'b1 && tx_if.tx_data === prev_data) else begin
                    err_cnt++;
                    $error("FAIL tx_hold: observed %b/%h, expected 1/%h",
                           tx_if.tx_valid, tx_if.tx_data, prev_data);
                end
            end
            if (fifo_rd_empty) begin
                chk_cnt++;
                assert (fifo_rd_en === 1'b0) else begin
                    err_cnt++;
                    $error("FAIL rd_while_empty: observed %b, expected 0", fifo_rd_en);
                end
            end
            prev_stall = tx_if.tx_valid && !tx_if.tx_ready;
            prev_data  = tx_if.tx_data;
            prev_abort = abort;
            if (fifo_rd_en) rd_cnt++;
            if (frame_done) done_cnt++;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_sample(input logic [11:0] v);
        mem[wr_ptr % 64] = v;
        wr_ptr++;
    endtask

    task automatic exp_sample(input logic [11:0] v, inout logic [7:0] cs);
        exp_q.push_back({4'h0, v[11:8]});
        exp_q.push_back(v[7:0]);
        cs = cs ^ {4'h0, v[11:8]} ^ v[7:0];
    endtask

    task automatic expect_frame();
        logic [7:0] cs = 8'h00;
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h5A);
        for (int i = 0; i < FL; i++)
            exp_sample(mem[(rd_ptr + i) % 64], cs);
        exp_q.push_back(cs);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input bit bp, input int budget);
        int d0 = done_cnt;
        int n  = 0;
        while (done_cnt == d0 && n < budget) begin
            tx_if.tx_ready = bp ? (n % 3 == 0) : 1'b1;
            @(posedge clk); #1;
            n++;
        end
        tx_if.tx_ready = 1'b1;
        check("frame_done", 32'(done_cnt - d0), 32'd1);
    endtask

    task automatic wait_xfers(input int base, input int target);
        int n = 0;
        while (xfer_cnt - base < target && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("xfer_reach", 32'(xfer_cnt - base), 32'(target));
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_valid"}, 32'(tx_if.tx_valid), 32'd0);
        check({tag, "_data"},  32'(tx_if.tx_data),  32'd0);
        check({tag, "_busy"},  32'(busy),           32'd0);
        check({tag, "_done"},  32'(frame_done),     32'd0);
        check({tag, "_rd_en"}, 32'(fifo_rd_en),     32'd0);
        check({tag, "_cnt"},   32'(sample_cnt),     32'd0);
    endtask

    initial begin
        int r0, d0, x0;
        logic [7:0] cs;

        rst_n = 1'b1; start = 1'b0; abort = 1'b0;
        force_empty = 1'b0; lvl_force = 1'b0; lvl_val = '0;
        tx_if.tx_ready = 1'b1;
        #1 rst_n = 1'b0;
        #2 check_idle_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // basic frame
        push_sample(12'hABC); push_sample(12'h123);
        push_sample(12'h000); push_sample(12'hFFF);
        expect_frame();
        r0 = rd_cnt; d0 = done_cnt;
        pulse_start();
        @(negedge clk);
        check("lat_valid", 32'(tx_if.tx_valid), 32'd1);
        check("lat_data",  32'(tx_if.tx_data),  32'hA5);
        check("lat_busy",  32'(busy),           32'd1);
        @(posedge clk); #1;
        wait_done(1'b0, 200);
        check("f1_reads", 32'(rd_cnt - r0), 32'd4);
        check("f1_cnt_hold", 32'(sample_cnt), 32'd4);
        check("f1_drained", 32'(exp_q.size()), 32'd0);
        repeat (3) @(posedge clk);
        #1 check("f1_done_once", 32'(done_cnt - d0), 32'd1);

        // backpressure
        push_sample(12'hABC); push_sample(12'h123);
        push_sample(12'h000); push_sample(12'hFFF);
        expect_frame();
        r0 = rd_cnt;
        pulse_start();
        wait_done(1'b1, 400);
        check("bp_reads", 32'(rd_cnt - r0), 32'd4);
        check("bp_drained", 32'(exp_q.size()), 32'd0);

        // underflow stall after the second read
        push_sample(12'h456); push_sample(12'h789);
        push_sample(12'hFED); push_sample(12'h00F);
        expect_frame();
        r0 = rd_cnt;
        pulse_start();
        for (int n = 0; n < 100 && rd_cnt - r0 < 2; n++) begin
            @(posedge clk); #1;
        end
        force_empty = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("uf_cnt", 32'(sample_cnt), 32'd2);
        check("uf_busy", 32'(busy), 32'd1);
        check("uf_stalled", 32'(tx_if.tx_valid), 32'd0);
        check("uf_reads", 32'(rd_cnt - r0), 32'd2);
        force_empty = 1'b0;
        wait_done(1'b0, 200);
        check("uf_reads_all", 32'(rd_cnt - r0), 32'd4);
        check("uf_drained", 32'(exp_q.size()), 32'd0);

        // start gate and start+abort in IDLE
        push_sample(12'h321); push_sample(12'hCBA);
        push_sample(12'hA0A); push_sample(12'h5F5);
        lvl_force = 1'b1; lvl_val = 11'd3;
        r0 = rd_cnt;
        pulse_start();
        repeat (4) @(posedge clk);
        #1;
        check("gate_busy", 32'(busy), 32'd0);
        check("gate_reads", 32'(rd_cnt - r0), 32'd0);
        lvl_force = 1'b0;
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        @(posedge clk); #1;
        check("sa_busy", 32'(busy), 32'd0);
        lvl_force = 1'b1; lvl_val = 11'd4;
        expect_frame();
        pulse_start();
        wait_done(1'b0, 200);
        lvl_force = 1'b0;
        check("gate_reads_all", 32'(rd_cnt - r0), 32'd4);
        check("gate_drained", 32'(exp_q.size()), 32'd0);

        // abort while sample 2 low byte is pending
        push_sample(12'h111); push_sample(12'h222);
        push_sample(12'h333); push_sample(12'h444);
        cs = 8'h00;
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h5A);
        exp_sample(12'h111, cs);
        exp_q.push_back(8'h02);
        x0 = xfer_cnt; d0 = done_cnt;
        pulse_start();
        wait_xfers(x0, 5);
        check("ab_lo_valid", 32'(tx_if.tx_valid), 32'd1);
        check("ab_lo_data", 32'(tx_if.tx_data), 32'h22);
        tx_if.tx_ready = 1'b0;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        tx_if.tx_ready = 1'b1;
        @(negedge clk);
        check("ab_valid", 32'(tx_if.tx_valid), 32'd0);
        check("ab_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        repeat (5) @(posedge clk);
        #1;
        check("ab_no_done", 32'(done_cnt - d0), 32'd0);
        check("ab_drained", 32'(exp_q.size()), 32'd0);
        push_sample(12'h555); push_sample(12'h666);
        expect_frame();
        pulse_start();
        wait_done(1'b0, 200);
        check("ab_restart_drained", 32'(exp_q.size()), 32'd0);

        // asynchronous reset mid-frame under backpressure
        push_sample(12'h777); push_sample(12'h888);
        push_sample(12'h999); push_sample(12'hAAA);
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h5A);
        exp_q.push_back(8'h07);
        x0 = xfer_cnt;
        pulse_start();
        wait_xfers(x0, 3);
        tx_if.tx_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #2 check_idle_zero("midrst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        tx_if.tx_ready = 1'b1;
        check("rst_drained", 32'(exp_q.size()), 32'd0);
        push_sample(12'hBBB);
        r0 = rd_cnt;
        expect_frame();
        pulse_start();
        wait_done(1'b0, 200);
        check("rst_reads", 32'(rd_cnt - r0), 32'd4);
        check("rst_frame_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
        $finish;
    end

endmodule
